zeroriscy_irq_arbiter: RTL
==========================

Name: zeroriscy_irq_arbiter

Overview:
- Collects up to 32 external interrupt sources and applies per-line enables and edge/level capture.
- Selects one winner and drives a single stable request/ID pair into the core's interrupt controller (its irq_i / irq_id_i inputs).
- Consumes the core's acknowledge to retire edge-captured requests and advance round-robin priority.
- Sits at the core boundary, between the SoC interrupt lines and the core.

Parameters:
- NUM_IRQ, 32, number of source lines (1..32); ID fixed 5 bits.
- EDGE_MASK, 32'h0, bit i=1 makes line i rising-edge-triggered, 0 makes it level-triggered.
- RR_EN, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- irq_lines_i  in  NUM_IRQ  source lines, already synchronous to clk
- en_we_i  in  1  enable-register write strobe
- en_wdata_i  in  NUM_IRQ  new enable mask
- en_o  out  NUM_IRQ  current enable mask
- pend_o  out  NUM_IRQ  effective pending vector (edge-pending OR level-high), before masking
- irq_o  out  1  request to core interrupt controller
- irq_id_o  out  5  ID of the request; stable while irq_o=1
- irq_ack_i  in  1  one-cycle acknowledge from core (ISR entry)
- irq_ack_id_i  in  5  ID being acknowledged

Behaviour:
- Reset (rst=1 at posedge), all registers cleared:
  - irq_o=0, irq_id_o=0, en_o=0, edge-pending=0, previous-sample=0, rr_ptr=0, state=IDLE.
  - Reset mid-ASSERT drops irq_o on the next edge. Any captured edges are lost.
- Edge capture (EDGE_MASK[i]=1):
  - prev_q[i] <= line[i] every cycle. Rising edge = line & ~prev_q.
  - Rising edge sets epend_q[i]; captured regardless of enable.
  - epend_q[i] is cleared only by a valid ack of ID i.
  - Same-cycle rising edge and ack on the same line: set wins, the new edge is kept.
- Level lines: pending[i] = line[i] combinationally; never stored.
- eligible = pending & en_q. Enable writes take effect from the next cycle.
- Selection (sub-module), among eligible lines:
  - RR_EN=0: lowest index wins.
  - RR_EN=1: first eligible index at or above rr_ptr, wrapping modulo NUM_IRQ.
- FSM states IDLE, ASSERT, CLAIMED:
  - IDLE: if any line is eligible, go to ASSERT, latch irq_id_o=winner, irq_o=1 (registered, one cycle after eligibility).
  - ASSERT, checked in this order:
    - irq_ack_i=1 and irq_ack_id_i==irq_id_o: go to CLAIMED, irq_o=0, clear epend_q[id], and if RR_EN set rr_ptr=(id+1) mod NUM_IRQ.
    - irq_ack_i=1 with an ID mismatch: ignored, stay in ASSERT.
    - Selected line no longer eligible (level dropped or enable cleared): go to IDLE, irq_o=0. The core's kill path handles a request it already latched.
    - A higher-priority arrival never preempts; irq_id_o stays frozen.
  - CLAIMED: one dead cycle (irq_o=0), then IDLE. This gives the core time to return its controller to IDLE before re-arbitration.
  - irq_ack_i outside ASSERT is ignored.
- Latency:
  - Level line high at cycle N gives irq_o=1 at N+1.
  - Edge line rising at N gives epend at N+1 and irq_o=1 at N+2.
  - Ack at N gives irq_o=0 at N+1; earliest re-assert is N+3.
- NUM_IRQ<32: unused IDs are never produced; rr_ptr wraps at NUM_IRQ-1 to 0.

Decomposition:
- zeroriscy_defines (shared package) holds:
  - IRQ_ID_W=5, MAX_IRQ=32.
  - The FSM enum irq_arb_state_e {IRQ_ARB_IDLE, IRQ_ARB_ASSERT, IRQ_ARB_CLAIMED}.
- One combinational sub-module, zeroriscy_irq_prio_sel:
  - Inputs: request vector and start pointer.
  - Outputs: valid flag and 5-bit index (rotate, find-first-one, un-rotate).
- Top level holds the enable, capture and pending registers and the FSM.

Test Plan:
- Reset with line 3 (level) high and en=0: irq_o=0, irq_id_o=0. Then write en=0x8: irq_o=1, irq_id_o=3 two cycles after the write strobe; ack id 3 gives irq_o=0 next cycle, and irq_o re-asserts id 3 three cycles after ack while the line stays high.
- EDGE_MASK bit5: pulse line 5 for 1 cycle with en=0, then enable: irq_o=1 with id 5 (edge retained). Ack id 5, then pend_o[5]=0. A second pulse in the same cycle as the ack leaves pend_o[5]=1.
- RR_EN=0, lines 2 and 7 level-high and enabled: id 2 is granted repeatedly. RR_EN=1: grants alternate 2,7,2 across successive acks.
- In ASSERT with id 7, raise line 1: irq_id_o stays 7. Ack with id 1: ignored, irq_o stays 1.
- In ASSERT with id 4 (level), drop line 4: irq_o=0 the next cycle, state IDLE, no ack required.
- Assert rst in ASSERT with epend nonzero: next cycle irq_o=0, pend_o=0, en_o=0.

Source files
------------

// File: rtl/zeroriscy_irq_arbiter_pkg.sv
// Shared definitions for the zero-riscy interrupt arbiter.
// Holds ID width, source limit and the arbiter FSM encoding.
package zeroriscy_defines;

    localparam int IRQ_ID_W = 5;
    localparam int MAX_IRQ  = 32;

    typedef enum logic [1:0] {
        IRQ_ARB_IDLE,
        IRQ_ARB_ASSERT,
        IRQ_ARB_CLAIMED
    } irq_arb_state_e;

endpackage

// File: rtl/zeroriscy_irq_prio_sel.sv
// Combinational priority selector: rotate by start,
// find first set bit, then un-rotate back to a line index.
module zeroriscy_irq_prio_sel
    import zeroriscy_defines::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0]          req,
    input  logic [IRQ_ID_W-1:0]   start,
    output logic                  valid,
    output logic [IRQ_ID_W-1:0]   idx
);

    localparam logic [IRQ_ID_W:0] NW = (IRQ_ID_W + 1)'(N);

    logic [N-1:0]        rot;
    logic [IRQ_ID_W-1:0] ffo;
    logic [IRQ_ID_W:0]   sum;

    // Rotate so start sits at bit 0, pick lowest set bit, map back
    always_comb begin
        rot   = N'({req, req} >> start);
        valid = |req;
        ffo   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) ffo = IRQ_ID_W'(k);
        end
        sum = {1'b0, start} + {1'b0, ffo};
        if (sum >= NW) sum = sum - NW;
        idx = sum[IRQ_ID_W-1:0];
    end

endmodule

// File: rtl/zeroriscy_irq_arbiter.sv
// Interrupt arbiter at the core boundary: enables, edge capture,
// winner selection and a stable irq/id handshake with the core.
module zeroriscy_irq_arbiter
    import zeroriscy_defines::*;
#(
    parameter int          NUM_IRQ   = 32,
    parameter logic [31:0] EDGE_MASK = 32'h0,
    parameter bit          RR_EN     = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQ-1:0]  irq_lines_i,
    input  logic                en_we_i,
    input  logic [NUM_IRQ-1:0]  en_wdata_i,
    output logic [NUM_IRQ-1:0]  en_o,
    output logic [NUM_IRQ-1:0]  pend_o,
    output logic                irq_o,
    output logic [4:0]          irq_id_o,
    input  logic                irq_ack_i,
    input  logic [4:0]          irq_ack_id_i
);

    localparam logic [NUM_IRQ-1:0] EM = EDGE_MASK[NUM_IRQ-1:0];
    localparam logic [IRQ_ID_W:0]  NW = (IRQ_ID_W + 1)'(NUM_IRQ);

    logic [NUM_IRQ-1:0]  en_q;
    logic [NUM_IRQ-1:0]  prev_q;
    logic [NUM_IRQ-1:0]  epend_q;
    logic [NUM_IRQ-1:0]  pend;
    logic [NUM_IRQ-1:0]  elig;
    logic [NUM_IRQ-1:0]  rise;
    logic [NUM_IRQ-1:0]  ack_clr;
    logic [MAX_IRQ-1:0]  elig_w;
    logic [MAX_IRQ-1:0]  ack_clr_w;
    logic [IRQ_ID_W-1:0] id_q, id_d;
    logic [IRQ_ID_W-1:0] rr_q, rr_d;
    logic [IRQ_ID_W-1:0] sel_start;
    logic [IRQ_ID_W-1:0] sel_idx;
    logic [IRQ_ID_W:0]   rr_nxt;
    logic                sel_valid;
    logic                ack_ok;

    irq_arb_state_e state_q, state_d;

    assign pend      = epend_q | (irq_lines_i & ~EM);
    assign elig      = pend & en_q;
    assign elig_w    = MAX_IRQ'(elig);
    assign rise      = irq_lines_i & ~prev_q & EM;
    assign ack_ok    = (state_q == IRQ_ARB_ASSERT) && irq_ack_i
                       && (irq_ack_id_i == id_q);
    assign ack_clr_w = ack_ok ? (MAX_IRQ'(1) << id_q) : '0;
    assign ack_clr   = ack_clr_w[NUM_IRQ-1:0];
    assign sel_start = RR_EN ? rr_q : '0;
    assign rr_nxt    = {1'b0, id_q} + (IRQ_ID_W + 1)'(1);

    zeroriscy_irq_prio_sel #(
        .N (NUM_IRQ)
    ) u_prio_sel (
        .req   (elig),
        .start (sel_start),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    // Enable mask and edge capture; a new edge beats a same-cycle ack
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q    <= '0;
            prev_q  <= '0;
            epend_q <= '0;
        end else begin
            if (en_we_i) en_q <= en_wdata_i;
            prev_q  <= irq_lines_i;
            epend_q <= (epend_q & ~ack_clr) | rise;
        end
    end

    // Arbiter state, latched ID and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IRQ_ARB_IDLE;
            id_q    <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
        end
    end

    // Next state: grant from IDLE, hold ID frozen while asserting
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        rr_d    = rr_q;
        unique case (state_q)
            IRQ_ARB_IDLE: begin
                if (sel_valid) begin
                    state_d = IRQ_ARB_ASSERT;
                    id_d    = sel_idx;
                end
            end
            IRQ_ARB_ASSERT: begin
                if (ack_ok) begin
                    state_d = IRQ_ARB_CLAIMED;
                    if (RR_EN) begin
                        rr_d = (rr_nxt == NW) ? '0
                                              : rr_nxt[IRQ_ID_W-1:0];
                    end
                end else if (!elig_w[id_q]) begin
                    state_d = IRQ_ARB_IDLE;
                end
            end
            IRQ_ARB_CLAIMED: begin
                state_d = IRQ_ARB_IDLE;
            end
            default: begin
                state_d = IRQ_ARB_IDLE;
            end
        endcase
    end

    assign irq_o    = (state_q == IRQ_ARB_ASSERT);
    assign irq_id_o = id_q;
    assign en_o     = en_q;
    assign pend_o   = pend;

endmodule
